// File: rtl/ramp_scan_peak.sv
// ramp_scan_peak: frames one half of the triangular ramp scan per window and
// tracks the maximum (or minimum) of a monitored signal inside that window.
// At window end the extremum value and the ramp value at its first
// occurrence are latched and announced with a single-cycle peak_valid.
module ramp_scan_peak #(
   parameter int R = 14
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                clear,
   input  logic                mode,
   input  logic                scan_dir,
   input  logic [31:0]         max_len,
   input  logic signed [R-1:0] ramp_in,
   input  logic                trig_low,
   input  logic                trig_hig,
   input  logic signed [R-1:0] sig_in,
   output logic signed [R-1:0] peak_val,
   output logic signed [R-1:0] peak_ramp,
   output logic                peak_valid,
   output logic                scan_abort,
   output logic [15:0]         scan_cnt,
   output logic                busy,
   output logic [1:0]          state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      SCAN = 2'd2
   } state_t;

   state_t              st;
   state_t              st_nxt;

   // window context, captured when the start trigger is accepted
   logic                mode_l;
   logic                dir_l;
   logic signed [R-1:0] best;
   logic signed [R-1:0] best_ramp;
   logic [31:0]         len;

   // ARM decodes triggers with the live direction, since that is the value
   // about to be latched; SCAN uses the latched one so pin changes mid-window
   // cannot move the window end.
   logic arm_start;
   logic arm_end;
   logic arm_go;
   logic scan_end;
   logic scan_tmo;
   logic better;
   logic signed [R-1:0] fin_val;
   logic signed [R-1:0] fin_ramp;

   assign arm_start = scan_dir ? trig_hig : trig_low;
   assign arm_end   = scan_dir ? trig_low : trig_hig;
   // both limits firing together means a degenerate scan range: ignore it
   assign arm_go    = arm_start && !arm_end;

   assign scan_end  = dir_l ? trig_low : trig_hig;
   // an end trigger on the timeout cycle still completes the window
   assign scan_tmo  = (max_len != 32'd0) && (len == max_len) && !scan_end;

   // strict compare keeps the earliest of equal samples
   assign better    = mode_l ? (sig_in < best) : (sig_in > best);
   assign fin_val   = better ? sig_in  : best;
   assign fin_ramp  = better ? ramp_in : best_ramp;

   // next-state decode: disable beats clear, clear beats normal sequencing
   always_comb begin
      st_nxt = st;
      if (!enable) begin
         st_nxt = IDLE;
      end else if (clear) begin
         st_nxt = ARM;
      end else begin
         case (st)
            IDLE:    st_nxt = ARM;
            ARM:     if (arm_go) st_nxt = SCAN;
            SCAN:    if (scan_end || scan_tmo) st_nxt = ARM;
            default: st_nxt = IDLE;
         endcase
      end
   end

   // state register with busy registered from the same next-state decode
   always_ff @(posedge clk) begin
      if (rst) begin
         st   <= IDLE;
         busy <= 1'b0;
      end else begin
         st   <= st_nxt;
         busy <= (st_nxt == SCAN);
      end
   end

   assign state = st;

   // window tracking, result latching and the single-cycle status pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         peak_val   <= '0;
         peak_ramp  <= '0;
         peak_valid <= 1'b0;
         scan_abort <= 1'b0;
         scan_cnt   <= '0;
         mode_l     <= 1'b0;
         dir_l      <= 1'b0;
         best       <= '0;
         best_ramp  <= '0;
         len        <= '0;
      end else begin
         peak_valid <= 1'b0;
         scan_abort <= 1'b0;
         if (clear) begin
            peak_val  <= '0;
            peak_ramp <= '0;
            scan_cnt  <= '0;
         end else if (enable) begin
            case (st)
               ARM: begin
                  if (arm_go) begin
                     mode_l    <= mode;
                     dir_l     <= scan_dir;
                     best      <= sig_in;
                     best_ramp <= ramp_in;
                     len       <= 32'd1;
                  end
               end
               SCAN: begin
                  if (scan_end) begin
                     peak_val   <= fin_val;
                     peak_ramp  <= fin_ramp;
                     peak_valid <= 1'b1;
                     scan_cnt   <= scan_cnt + 16'd1;
                  end else if (scan_tmo) begin
                     scan_abort <= 1'b1;
                  end else begin
                     if (better) begin
                        best      <= sig_in;
                        best_ramp <= ramp_in;
                     end
                     if (len != 32'hFFFF_FFFF) len <= len + 32'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ramp_scan_peak.sv
// Bench for ramp_scan_peak: directed and randomized windows checked against
// a queue-based model that finds the window extremum and its first position.
module tb_ramp_scan_peak;

   localparam int R = 14;

   logic                clk = 1'b0;
   logic                rst, enable, clear, mode, scan_dir;
   logic [31:0]         max_len;
   logic signed [R-1:0] ramp_in, sig_in;
   logic                trig_low, trig_hig;
   logic signed [R-1:0] peak_val, peak_ramp;
   logic                peak_valid, scan_abort, busy;
   logic [15:0]         scan_cnt;
   logic [1:0]          state;

   int total = 0;
   int passed = 0;
   int nvalid = 0;
   int nabort = 0;

   logic signed [R-1:0] ws[$];
   logic signed [R-1:0] wr[$];
   logic signed [R-1:0] exp_val, exp_ramp;
   logic [15:0]         exp_cnt;

   ramp_scan_peak #(.R(R)) dut (
      .clk(clk), .rst(rst), .enable(enable), .clear(clear), .mode(mode),
      .scan_dir(scan_dir), .max_len(max_len), .ramp_in(ramp_in),
      .trig_low(trig_low), .trig_hig(trig_hig), .sig_in(sig_in),
      .peak_val(peak_val), .peak_ramp(peak_ramp), .peak_valid(peak_valid),
      .scan_abort(scan_abort), .scan_cnt(scan_cnt), .busy(busy), .state(state)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (peak_valid) nvalid++;
      if (scan_abort) nabort++;
   end

   initial begin
      #20000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // model: extremum over the whole window, then the first sample holding it
   task automatic ref_peak(input bit md, output logic signed [R-1:0] v,
                           output logic signed [R-1:0] r);
      v = ws[0];
      foreach (ws[i]) if (md ? (ws[i] < v) : (ws[i] > v)) v = ws[i];
      r = 'x;
      for (int i = 0; i < ws.size(); i++)
         if (ws[i] == v) begin r = wr[i]; break; end
   endtask

   task automatic fill_rand(input int n, input int span);
      ws.delete(); wr.delete();
      for (int i = 0; i < n; i++) begin
         ws.push_back(R'(int'($urandom_range(0, 2*span)) - span));
         wr.push_back(R'($urandom));
      end
   endtask

   // drive the queued window: sample 0 on the start trigger, last on the end
   task automatic drive_window(input bit dir, input bit md, input bit tog,
                               output bit saw_scan);
      int n = ws.size();
      saw_scan = 1'b0;
      for (int i = 0; i < n; i++) begin
         sig_in = ws[i]; ramp_in = wr[i];
         trig_low = 1'b0; trig_hig = 1'b0;
         if (i == 0) begin
            scan_dir = dir; mode = md;
            if (dir) trig_hig = 1'b1; else trig_low = 1'b1;
         end else begin
            if (tog) begin mode = 1'($urandom); scan_dir = 1'($urandom); end
            if (i == n-1) begin if (dir) trig_low = 1'b1; else trig_hig = 1'b1; end
         end
         step();
         if (i == 0) saw_scan = (state == 2'd2) && busy;
      end
      trig_low = 1'b0; trig_hig = 1'b0; mode = md; scan_dir = dir;
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; clear = 1'b0; mode = 1'b0; scan_dir = 1'b0;
      max_len = 0; ramp_in = 0; sig_in = 0; trig_low = 0; trig_hig = 0;
      step(); step();
      total++;
      if ({peak_val, peak_ramp, peak_valid, scan_abort, scan_cnt, busy, state} !== '0)
         $display("FAIL reset_outputs: val=%0d ramp=%0d pv=%b ab=%b cnt=%0d busy=%b st=%0d, want all 0",
                  peak_val, peak_ramp, peak_valid, scan_abort, scan_cnt, busy, state);
      else passed++;
      rst = 1'b0; enable = 1'b1;
      step();
      total++;
      if (state !== 2'd1) $display("FAIL reset_to_arm: state=%0d want 1", state); else passed++;
      exp_val = 0; exp_ramp = 0; exp_cnt = 0;
   endtask

   task automatic test_rise_max();
      bit s; int nv; int v;
      ws.delete(); wr.delete();
      for (int r = -100; r <= 100; r++) begin
         v = r - 37;
         wr.push_back(R'(r));
         ws.push_back(R'(v < 0 ? v : -v));
      end
      nv = nvalid;
      drive_window(1'b0, 1'b0, 1'b0, s);
      exp_cnt++;
      total++;
      if (!s) $display("FAIL rise_busy: scan state not seen after start"); else passed++;
      total++;
      if (peak_valid !== 1'b1 || peak_val !== 0 || peak_ramp !== 37 || scan_cnt !== exp_cnt)
         $display("FAIL rise_result: pv=%b val=%0d ramp=%0d cnt=%0d, want pv=1 val=0 ramp=37 cnt=%0d",
                  peak_valid, peak_val, peak_ramp, scan_cnt, exp_cnt);
      else passed++;
      total++;
      if (state !== 2'd1 || busy !== 1'b0)
         $display("FAIL rise_back_to_arm: state=%0d busy=%b want 1/0", state, busy);
      else passed++;
      step();
      total++;
      if (peak_valid !== 1'b0 || nvalid - nv != 1)
         $display("FAIL rise_pulse_width: pv=%b pulses=%0d want 0/1", peak_valid, nvalid - nv);
      else passed++;
      exp_val = 0; exp_ramp = 37;
   endtask

   task automatic test_fall_min_ties();
      bit s; logic signed [R-1:0] mv, mr;
      for (int pass = 0; pass < 2; pass++) begin
         ws.delete(); wr.delete();
         for (int r = 100; r >= 10; r--) begin
            wr.push_back(R'(r));
            if (r == 50 || r == 20) ws.push_back(R'(-8000));
            else if (pass == 1 && r == 10) ws.push_back(R'(-8191));
            else ws.push_back(R'(int'($urandom_range(0, 14000)) - 7000));
         end
         ref_peak(1'b1, mv, mr);
         drive_window(1'b1, 1'b1, 1'b0, s);
         exp_cnt++;
         total++;
         if (peak_valid !== 1'b1 || peak_val !== mv || peak_ramp !== mr || scan_cnt !== exp_cnt)
            $display("FAIL fall_min_pass%0d: pv=%b val=%0d ramp=%0d cnt=%0d, want 1 %0d %0d %0d",
                     pass, peak_valid, peak_val, peak_ramp, scan_cnt, mv, mr, exp_cnt);
         else passed++;
         total++;
         if (pass == 0 ? (peak_ramp !== 50) : (peak_val !== -8191 || peak_ramp !== 10))
            $display("FAIL fall_min_const%0d: val=%0d ramp=%0d", pass, peak_val, peak_ramp);
         else passed++;
         exp_val = mv; exp_ramp = mr;
         step();
      end
   endtask

   task automatic test_timeout();
      int abort_at = 0; int nab = 0; logic [1:0] st11 = 0; int nv;
      bit s; logic signed [R-1:0] mv, mr;
      max_len = 10; scan_dir = 1'b0; mode = 1'b0;
      nv = nvalid;
      trig_low = 1'b1; sig_in = R'(-8191); ramp_in = 5;
      step();
      trig_low = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         if (scan_abort) begin nab++; if (abort_at == 0) abort_at = k; end
         if (k == 11) st11 = state;
         sig_in = R'(8000 + k); ramp_in = R'(k);
         step();
      end
      total++;
      if (abort_at != 11 || nab != 1 || st11 !== 2'd1)
         $display("FAIL timeout_abort: at=%0d count=%0d state=%0d, want 11/1/1", abort_at, nab, st11);
      else passed++;
      total++;
      if (peak_val !== exp_val || peak_ramp !== exp_ramp || scan_cnt !== exp_cnt || nvalid != nv)
         $display("FAIL timeout_unchanged: val=%0d ramp=%0d cnt=%0d pulses=%0d, want %0d %0d %0d 0",
                  peak_val, peak_ramp, scan_cnt, nvalid - nv, exp_val, exp_ramp, exp_cnt);
      else passed++;
      // end trigger lands exactly on the timeout cycle (len == max_len)
      fill_rand(11, 8000);
      ref_peak(1'b0, mv, mr);
      drive_window(1'b0, 1'b0, 1'b0, s);
      exp_cnt++;
      total++;
      if (peak_valid !== 1'b1 || scan_abort !== 1'b0 || peak_val !== mv || peak_ramp !== mr)
         $display("FAIL timeout_end_wins: pv=%b ab=%b val=%0d ramp=%0d, want 1 0 %0d %0d",
                  peak_valid, scan_abort, peak_val, peak_ramp, mv, mr);
      else passed++;
      exp_val = mv; exp_ramp = mr;
      max_len = 0;
      step();
   endtask

   task automatic test_mid_control();
      bit s; logic signed [R-1:0] mv, mr; int nv, na;
      // pins flip every SCAN cycle; end uses the latched direction
      fill_rand(25, 8000);
      ref_peak(1'b0, mv, mr);
      drive_window(1'b0, 1'b0, 1'b1, s);
      exp_cnt++;
      total++;
      if (peak_valid !== 1'b1 || peak_val !== mv || peak_ramp !== mr || scan_cnt !== exp_cnt)
         $display("FAIL mid_toggle: pv=%b val=%0d ramp=%0d cnt=%0d, want 1 %0d %0d %0d",
                  peak_valid, peak_val, peak_ramp, scan_cnt, mv, mr, exp_cnt);
      else passed++;
      exp_val = mv; exp_ramp = mr;
      step();
      // enable drops mid-window
      nv = nvalid; na = nabort;
      trig_low = 1'b1; sig_in = 100; step(); trig_low = 1'b0;
      step(); step();
      enable = 1'b0; step();
      total++;
      if (state !== 2'd0 || busy !== 1'b0 || peak_valid !== 1'b0)
         $display("FAIL disable_idle: state=%0d busy=%b pv=%b want 0/0/0", state, busy, peak_valid);
      else passed++;
      enable = 1'b1; step(); step();
      total++;
      if (state !== 2'd1 || nvalid != nv || nabort != na || peak_val !== exp_val || scan_cnt !== exp_cnt)
         $display("FAIL disable_silent: state=%0d pulses=%0d/%0d val=%0d cnt=%0d",
                  state, nvalid - nv, nabort - na, peak_val, scan_cnt);
      else passed++;
      // clear on the same cycle as the end trigger
      trig_low = 1'b1; sig_in = 1234; ramp_in = 77; step(); trig_low = 1'b0;
      step(); step();
      trig_hig = 1'b1; clear = 1'b1; step(); trig_hig = 1'b0; clear = 1'b0;
      total++;
      if (peak_val !== 0 || peak_ramp !== 0 || scan_cnt !== 0 || peak_valid !== 1'b0 || state !== 2'd1)
         $display("FAIL clear_with_end: val=%0d ramp=%0d cnt=%0d pv=%b state=%0d, want 0 0 0 0 1",
                  peak_val, peak_ramp, scan_cnt, peak_valid, state);
      else passed++;
      step();
      total++;
      if (nvalid != nv || nabort != na)
         $display("FAIL clear_no_pulse: pulses=%0d/%0d want 0/0", nvalid - nv, nabort - na);
      else passed++;
      exp_val = 0; exp_ramp = 0; exp_cnt = 0;
   endtask

   task automatic test_back_to_back();
      bit s; logic signed [R-1:0] mv, mr; int nv;
      trig_low = 1'b1; trig_hig = 1'b1; step(); trig_low = 1'b0; trig_hig = 1'b0;
      total++;
      if (state !== 2'd1 || busy !== 1'b0)
         $display("FAIL degenerate_trig: state=%0d busy=%b want 1/0", state, busy);
      else passed++;
      nv = nvalid;
      fill_rand(5, 500);
      ref_peak(1'b1, mv, mr);
      drive_window(1'b0, 1'b1, 1'b0, s);
      exp_cnt++;
      total++;
      if (peak_valid !== 1'b1 || peak_val !== mv || peak_ramp !== mr)
         $display("FAIL b2b_first: pv=%b val=%0d ramp=%0d, want 1 %0d %0d",
                  peak_valid, peak_val, peak_ramp, mv, mr);
      else passed++;
      fill_rand(4, 500);
      ref_peak(1'b0, mv, mr);
      drive_window(1'b1, 1'b0, 1'b0, s);
      exp_cnt++;
      total++;
      if (!s || peak_valid !== 1'b1 || peak_val !== mv || peak_ramp !== mr || scan_cnt !== exp_cnt)
         $display("FAIL b2b_second: scan=%b pv=%b val=%0d ramp=%0d cnt=%0d, want 1 1 %0d %0d %0d",
                  s, peak_valid, peak_val, peak_ramp, scan_cnt, mv, mr, exp_cnt);
      else passed++;
      exp_val = mv; exp_ramp = mr;
      step();
      total++;
      if (nvalid - nv != 2) $display("FAIL b2b_pulses: got %0d want 2", nvalid - nv); else passed++;
   endtask

   task automatic test_random();
      bit s, dir, md, tog; logic signed [R-1:0] mv, mr; int gap;
      for (int w = 0; w < 16; w++) begin
         dir = 1'($urandom); md = 1'($urandom); tog = 1'($urandom);
         fill_rand($urandom_range(2, 40), ($urandom_range(0, 1) == 1) ? 8191 : 3);
         ref_peak(md, mv, mr);
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) step();
         drive_window(dir, md, tog, s);
         exp_cnt++;
         total++;
         if (!s || peak_valid !== 1'b1 || peak_val !== mv || peak_ramp !== mr || scan_cnt !== exp_cnt)
            $display("FAIL random_w%0d: scan=%b pv=%b val=%0d ramp=%0d cnt=%0d, want 1 1 %0d %0d %0d",
                     w, s, peak_valid, peak_val, peak_ramp, scan_cnt, mv, mr, exp_cnt);
         else passed++;
         exp_val = mv; exp_ramp = mr;
      end
      step();
   endtask

   task automatic test_reset_mid();
      bit s; logic signed [R-1:0] mv, mr;
      trig_low = 1'b1; sig_in = 999; step(); trig_low = 1'b0;
      step(); step();
      rst = 1'b1; step(); rst = 1'b0;
      total++;
      if ({peak_val, peak_ramp, peak_valid, scan_abort, scan_cnt, busy, state} !== '0)
         $display("FAIL reset_mid: val=%0d ramp=%0d pv=%b ab=%b cnt=%0d busy=%b st=%0d, want all 0",
                  peak_val, peak_ramp, peak_valid, scan_abort, scan_cnt, busy, state);
      else passed++;
      step();
      exp_cnt = 0;
      fill_rand(6, 8191);
      ref_peak(1'b1, mv, mr);
      drive_window(1'b1, 1'b1, 1'b0, s);
      exp_cnt++;
      total++;
      if (!s || peak_valid !== 1'b1 || peak_val !== mv || peak_ramp !== mr || scan_cnt !== exp_cnt)
         $display("FAIL reset_mid_next: scan=%b pv=%b val=%0d ramp=%0d cnt=%0d, want 1 1 %0d %0d %0d",
                  s, peak_valid, peak_val, peak_ramp, scan_cnt, mv, mr, exp_cnt);
      else passed++;
      step();
   endtask

   task automatic test_wrap();
      int nv;
      clear = 1'b1; step(); clear = 1'b0; step();
      scan_dir = 1'b0; mode = 1'b0; sig_in = 0; ramp_in = 0;
      nv = nvalid;
      for (int w = 0; w < 65535; w++) begin
         trig_low = 1'b1; step(); trig_low = 1'b0;
         trig_hig = 1'b1; step(); trig_hig = 1'b0;
      end
      total++;
      if (scan_cnt !== 16'hFFFF) $display("FAIL wrap_preload: cnt=%0d want 65535", scan_cnt); else passed++;
      trig_low = 1'b1; step(); trig_low = 1'b0;
      trig_hig = 1'b1; step(); trig_hig = 1'b0;
      total++;
      if (scan_cnt !== 16'h0000 || peak_valid !== 1'b1)
         $display("FAIL wrap_zero: cnt=%0d pv=%b want 0/1", scan_cnt, peak_valid);
      else passed++;
      step();
      total++;
      if (nvalid - nv != 65536) $display("FAIL wrap_pulses: got %0d want 65536", nvalid - nv); else passed++;
   endtask

   initial begin
      test_reset();
      test_rise_max();
      test_fall_min_ties();
      test_timeout();
      test_mid_control();
      test_back_to_back();
      test_random();
      test_reset_mid();
      test_wrap();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
